// File: rtl/slice_coeff_seq.sv
// Coefficient table and window-position sequencer feeding one slice accumulator.
// Emits pixel, matching signed coefficient, block-end strobe and download/flush control.
module slice_coeff_seq #(
    parameter int DWIDTH     = 8,
    parameter int CWIDTH     = 9,
    parameter int BLOCKSIZE  = 8,
    parameter int WINCOLS    = 8,
    parameter int LINEBLOCKS = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              dvi_i,
    input  logic              sof_i,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic [CWIDTH-1:0] cfg_data,
    output logic              cfg_done,
    output logic [DWIDTH-1:0] data_o,
    output logic              dvi_o,
    output logic [CWIDTH-1:0] svcoeff,
    output logic              newblock,
    output logic              download
);

    localparam int DEPTH = WINCOLS * BLOCKSIZE;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = (BLOCKSIZE > 1) ? $clog2(BLOCKSIZE) : 1;
    localparam int BW    = (WINCOLS > 1) ? $clog2(WINCOLS) : 1;
    localparam int LW    = (LINEBLOCKS > 1) ? $clog2(LINEBLOCKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_RUN
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_waddr;
    logic [LW-1:0]     r_fcnt;
    logic [PW-1:0]     r_pix;
    logic [BW-1:0]     r_blk;
    logic [LW-1:0]     r_lblk;
    logic [CWIDTH-1:0] r_ram [DEPTH];

    logic              r_cfg_done;
    logic [DWIDTH-1:0] r_data;
    logic              r_dvi;
    logic [CWIDTH-1:0] r_coeff;
    logic              r_newblock;
    logic              r_download;

    logic [PW-1:0] w_pix;
    logic [BW-1:0] w_blk;
    logic [LW-1:0] w_lblk;
    logic [AW-1:0] w_raddr;
    logic          w_accept;
    logic          w_wr;
    logic          w_pix_last;
    logic          w_blk_last;
    logic          w_lblk_last;

    // Start of frame overrides the stored position for this cycle's pixel.
    assign w_pix       = sof_i ? '0 : r_pix;
    assign w_blk       = sof_i ? '0 : r_blk;
    assign w_lblk      = sof_i ? '0 : r_lblk;
    assign w_raddr     = {w_blk, w_pix};
    assign w_accept    = (r_state == S_RUN) && dvi_i;
    assign w_wr        = (r_state == S_LOAD) && cfg_valid && !cfg_start;
    assign w_pix_last  = (w_pix == PW'(BLOCKSIZE - 1));
    assign w_blk_last  = (w_blk == BW'(WINCOLS - 1));
    assign w_lblk_last = (w_lblk == LW'(LINEBLOCKS - 1));

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_ram[r_waddr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_waddr    <= '0;
            r_fcnt     <= '0;
            r_pix      <= '0;
            r_blk      <= '0;
            r_lblk     <= '0;
            r_cfg_done <= 1'b0;
            r_data     <= '0;
            r_dvi      <= 1'b0;
            r_coeff    <= '0;
            r_newblock <= 1'b0;
            r_download <= 1'b0;
        end else begin
            // Download trails the state by a cycle so an in-flight pixel never overlaps it.
            r_download <= (r_state == S_LOAD) || (r_state == S_FLUSH);
            r_cfg_done <= (r_state == S_FLUSH) && (r_fcnt == '0) && !cfg_start;
            r_dvi      <= w_accept;
            r_newblock <= w_accept && w_pix_last;
            if (w_accept) begin
                r_data  <= data_i;
                r_coeff <= r_ram[w_raddr];
            end

            if (r_state != S_RUN) begin
                r_pix  <= '0;
                r_blk  <= '0;
                r_lblk <= '0;
            end else if (w_accept) begin
                if (w_pix_last) begin
                    r_pix <= '0;
                    if (w_lblk_last) begin
                        r_lblk <= '0;
                        r_blk  <= '0;
                    end else begin
                        r_lblk <= w_lblk + 1'b1;
                        r_blk  <= w_blk_last ? '0 : w_blk + 1'b1;
                    end
                end else begin
                    r_pix  <= w_pix + 1'b1;
                    r_blk  <= w_blk;
                    r_lblk <= w_lblk;
                end
            end else if (sof_i) begin
                r_pix  <= '0;
                r_blk  <= '0;
                r_lblk <= '0;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_state <= S_LOAD;
                        r_waddr <= '0;
                    end
                end
                S_LOAD: begin
                    if (cfg_start) begin
                        r_waddr <= '0;
                    end else if (cfg_valid) begin
                        if (r_waddr == AW'(DEPTH - 1)) begin
                            r_state <= S_FLUSH;
                            r_fcnt  <= LW'(LINEBLOCKS - 1);
                        end else begin
                            r_waddr <= r_waddr + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (cfg_start) begin
                        r_state <= S_LOAD;
                        r_waddr <= '0;
                    end else if (r_fcnt == '0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_fcnt <= r_fcnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (cfg_start) begin
                        r_state <= S_LOAD;
                        r_waddr <= '0;
                    end
                end
            endcase
        end
    end

    assign cfg_done = r_cfg_done;
    assign data_o   = r_data;
    assign dvi_o    = r_dvi;
    assign svcoeff  = r_coeff;
    assign newblock = r_newblock;
    assign download = r_download;

endmodule

// File: tb/tb_slice_coeff_seq.sv
// Bench: two sequencers (40 and 37 blocks per line) against a per-cycle behavioural model.
// Randomised pixel traffic plus literal spot checks on coefficient order and strobes.
module tb_slice_coeff_seq;

    localparam int BS    = 8;
    localparam int WC    = 8;
    localparam int DEPTH = BS * WC;
    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_FLUSH = 2;
    localparam int M_RUN   = 3;

    typedef struct packed {
        logic [1:0][7:0] data;
        logic [1:0]      dvi;
        logic [1:0][8:0] coeff;
        logic [1:0]      nb;
        logic [1:0]      dl;
        logic [1:0]      done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_i;
    logic       dvi_i;
    logic       sof_i;
    logic       cfg_start;
    logic       cfg_valid;
    logic [8:0] cfg_data;

    logic       done_w  [2];
    logic [7:0] dout_w  [2];
    logic       dvi_w   [2];
    logic [8:0] coeff_w [2];
    logic       nb_w    [2];
    logic       dl_w    [2];

    int checks = 0;
    int errors = 0;
    int dl_cnt   [2];
    int done_cnt [2];

    exp_t expq[$];
    exp_t ce;

    int         m_mode [2];
    int         m_w    [2];
    int         m_rem  [2];
    int         m_pix  [2];
    int         m_blk  [2];
    int         m_lblk [2];
    logic [7:0] m_data [2];
    logic [8:0] m_coeff[2];
    logic [8:0] tbl    [2][DEPTH];

    always #5 clk = ~clk;

    slice_coeff_seq #(.LINEBLOCKS(40)) dut0 (
        .clk(clk), .reset(reset), .data_i(data_i), .dvi_i(dvi_i),
        .sof_i(sof_i), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .cfg_done(done_w[0]), .data_o(dout_w[0]),
        .dvi_o(dvi_w[0]), .svcoeff(coeff_w[0]), .newblock(nb_w[0]),
        .download(dl_w[0])
    );

    slice_coeff_seq #(.LINEBLOCKS(37)) dut1 (
        .clk(clk), .reset(reset), .data_i(data_i), .dvi_i(dvi_i),
        .sof_i(sof_i), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .cfg_done(done_w[1]), .data_o(dout_w[1]),
        .dvi_o(dvi_w[1]), .svcoeff(coeff_w[1]), .newblock(nb_w[1]),
        .download(dl_w[1])
    );

    task automatic chk(input string n, input int d,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d: actual %0h required %0h at %0t",
                     n, d, act, req, $time);
        end
    endtask

    // Model one clock: predict outputs after the edge from this cycle's inputs.
    task automatic step();
        exp_t e;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            int p, b, l, lb;
            lb = (d == 0) ? 40 : 37;
            if (reset) begin
                m_mode[d]  = M_IDLE;
                m_pix[d]   = 0;
                m_blk[d]   = 0;
                m_lblk[d]  = 0;
                m_data[d]  = '0;
                m_coeff[d] = '0;
            end else begin
                e.dl[d]   = (m_mode[d] == M_LOAD) || (m_mode[d] == M_FLUSH);
                e.done[d] = (m_mode[d] == M_FLUSH) && (m_rem[d] == 1) && !cfg_start;
                p = sof_i ? 0 : m_pix[d];
                b = sof_i ? 0 : m_blk[d];
                l = sof_i ? 0 : m_lblk[d];
                if (m_mode[d] == M_RUN && dvi_i) begin
                    e.dvi[d]   = 1'b1;
                    e.nb[d]    = (p == BS - 1);
                    m_data[d]  = data_i;
                    m_coeff[d] = tbl[d][b * BS + p];
                    p++;
                    if (p == BS) begin
                        p = 0;
                        b = (b + 1) % WC;
                        l++;
                        if (l == lb) begin
                            l = 0;
                            b = 0;
                        end
                    end
                end
                if (m_mode[d] == M_RUN && !cfg_start) begin
                    m_pix[d]  = p;
                    m_blk[d]  = b;
                    m_lblk[d] = l;
                end else begin
                    m_pix[d]  = 0;
                    m_blk[d]  = 0;
                    m_lblk[d] = 0;
                end
                case (m_mode[d])
                    M_IDLE: if (cfg_start) begin
                        m_mode[d] = M_LOAD;
                        m_w[d] = 0;
                    end
                    M_LOAD: if (cfg_start) begin
                        m_w[d] = 0;
                    end else if (cfg_valid) begin
                        tbl[d][m_w[d]] = cfg_data;
                        if (m_w[d] == DEPTH - 1) begin
                            m_mode[d] = M_FLUSH;
                            m_rem[d]  = lb;
                        end else begin
                            m_w[d]++;
                        end
                    end
                    M_FLUSH: if (cfg_start) begin
                        m_mode[d] = M_LOAD;
                        m_w[d] = 0;
                    end else begin
                        m_rem[d]--;
                        if (m_rem[d] == 0) m_mode[d] = M_RUN;
                    end
                    default: if (cfg_start) begin
                        m_mode[d] = M_LOAD;
                        m_w[d] = 0;
                    end
                endcase
            end
            e.data[d]  = m_data[d];
            e.coeff[d] = m_coeff[d];
        end
        expq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (expq.size() > 0) begin
            ce = expq.pop_front();
            for (int d = 0; d < 2; d++) begin
                chk("dvi_o", d, 32'(dvi_w[d]), 32'(ce.dvi[d]));
                chk("newblock", d, 32'(nb_w[d]), 32'(ce.nb[d]));
                chk("download", d, 32'(dl_w[d]), 32'(ce.dl[d]));
                chk("cfg_done", d, 32'(done_w[d]), 32'(ce.done[d]));
                chk("data_o", d, 32'(dout_w[d]), 32'(ce.data[d]));
                chk("svcoeff", d, 32'(coeff_w[d]), 32'(ce.coeff[d]));
                chk("dl_dvi_excl", d, 32'(dl_w[d] & dvi_w[d]), 32'd0);
                if (dl_w[d]) dl_cnt[d]++;
                if (done_w[d]) done_cnt[d]++;
            end
        end
    end

    task automatic idle(input int n);
        dvi_i = 1'b0;
        sof_i = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic words(input int n, input bit gaps, input bit ramp);
        int k;
        k = 0;
        while (k < n) begin
            dvi_i  = 1'($urandom % 2);
            data_i = 8'($urandom);
            sof_i  = 1'b0;
            if (gaps && ($urandom % 4 == 0)) begin
                cfg_valid = 1'b0;
            end else begin
                cfg_valid = 1'b1;
                cfg_data  = ramp ? 9'(k - 32) : 9'($urandom);
                k++;
            end
            step();
        end
        cfg_valid = 1'b0;
        dvi_i = 1'b0;
    endtask

    task automatic load(input bit gaps, input bit ramp);
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        dvi_i = 1'b0;
        step();
        cfg_start = 1'b0;
        words(DEPTH, gaps, ramp);
    endtask

    task automatic rand_px(input int n, input bit sof_first);
        for (int i = 0; i < n; i++) begin
            dvi_i  = ($urandom_range(0, 3) != 0);
            sof_i  = (sof_first && i == 0) || ($urandom % 128 == 0);
            data_i = 8'($urandom);
            step();
        end
        dvi_i = 1'b0;
        sof_i = 1'b0;
    endtask

    task automatic px(input bit sof, input logic [7:0] v);
        dvi_i  = 1'b1;
        sof_i  = sof;
        data_i = v;
        step();
        dvi_i = 1'b0;
        sof_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        data_i = '0;
        dvi_i = 1'b0;
        sof_i = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = '0;
        repeat (3) step();
        reset = 1'b0;
        rand_px(10, 1'b0);

        // Reset in the middle of a load.
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        words(5, 1'b0, 1'b1);
        reset = 1'b1;
        cfg_valid = 1'b1;
        step();
        for (int d = 0; d < 2; d++) chk("reset_dl", d, 32'(dl_w[d]), 32'd0);
        repeat (2) step();
        reset = 1'b0;
        cfg_valid = 1'b0;
        idle(3);

        // Ramp table k-32, gapless load.
        for (int d = 0; d < 2; d++) begin
            dl_cnt[d] = 0;
            done_cnt[d] = 0;
        end
        load(1'b0, 1'b1);
        idle(45);
        chk("dl_len", 0, 32'(dl_cnt[0]), 32'd104);
        chk("dl_len", 1, 32'(dl_cnt[1]), 32'd101);
        chk("done_cnt", 0, 32'(done_cnt[0]), 32'd1);
        chk("done_cnt", 1, 32'(done_cnt[1]), 32'd1);

        // Gapless run across window and line boundaries.
        for (int i = 0; i < 400; i++) begin
            px(i == 0, 8'd1);
            if (i == 0) begin
                chk("px0", 0, 32'(coeff_w[0]), 32'h1E0);
                chk("px0", 1, 32'(coeff_w[1]), 32'h1E0);
            end
            if (i == 7) chk("nb7", 0, 32'(nb_w[0]), 32'd1);
            if (i == 31) chk("px31", 0, 32'(coeff_w[0]), 32'h1FF);
            if (i == 63) chk("px63", 0, 32'(coeff_w[0]), 32'h01F);
            if (i == 64) chk("px64", 0, 32'(coeff_w[0]), 32'h1E0);
            if (i == 296) begin
                chk("px296", 0, 32'(coeff_w[0]), 32'h008);
                chk("px296", 1, 32'(coeff_w[1]), 32'h1E0);
            end
            if (i == 320) begin
                chk("px320", 0, 32'(coeff_w[0]), 32'h1E0);
                chk("px320", 1, 32'(coeff_w[1]), 32'h1F8);
            end
        end

        // Gaps and start-of-frame placement.
        idle(1);
        sof_i = 1'b1;
        step();
        sof_i = 1'b0;
        rand_px(500, 1'b0);
        repeat (3) px(1'b0, 8'h55);
        px(1'b1, 8'hAA);
        for (int d = 0; d < 2; d++) chk("sof_dvi", d, 32'(coeff_w[d]), 32'h1E0);
        repeat (3) px(1'b0, 8'h11);
        sof_i = 1'b1;
        step();
        sof_i = 1'b0;
        px(1'b0, 8'h22);
        for (int d = 0; d < 2; d++) chk("sof_only", d, 32'(coeff_w[d]), 32'h1E0);
        px(1'b0, 8'h23);
        for (int d = 0; d < 2; d++) chk("sof_next", d, 32'(coeff_w[d]), 32'h1E1);

        // Reload from RUN with a pixel in flight and a restart inside LOAD.
        repeat (5) px(1'b0, 8'h33);
        cfg_start = 1'b1;
        px(1'b0, 8'h44);
        cfg_start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("inflight_dvi", d, 32'(dvi_w[d]), 32'd1);
            chk("inflight_dl", d, 32'(dl_w[d]), 32'd0);
        end
        px(1'b0, 8'h45);
        for (int d = 0; d < 2; d++) begin
            chk("reload_dvi", d, 32'(dvi_w[d]), 32'd0);
            chk("reload_dl", d, 32'(dl_w[d]), 32'd1);
        end
        words(10, 1'b1, 1'b0);
        load(1'b1, 1'b0);
        rand_px(45, 1'b0);
        rand_px(300, 1'b1);

        // Restart from inside FLUSH.
        load(1'b0, 1'b0);
        idle(10);
        load(1'b1, 1'b0);
        idle(45);
        rand_px(300, 1'b1);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
